bus_dma_master: RTL and testbench

//  Word-copy DMA engine acting as an initiator on the native valid/ready memory bus
//  (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata), i.e. the master side of
//  the interface the interconnect routes to ROM/RAM/matrix accelerator. Copies LEN words

---
 rtl/bus_dma_master_if.sv | 26 ++
 rtl/bus_dma_master.sv | 161 ++++++++++++++++
 tb/tb_bus_dma_master.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_dma_master_if.sv
// Native valid/ready memory bus between an initiator and the interconnect.
//   mem_valid  initiator -> target  request strobe
//   mem_ready  target -> initiator  acknowledge; transfer on mem_valid & mem_ready
//   mem_addr   initiator -> target  word-aligned byte address
//   mem_wdata  initiator -> target  write data
//   mem_wstrb  initiator -> target  4'h0 read, 4'hF write
//   mem_rdata  target -> initiator  read data, valid during the transfer cycle
`timescale 1ns/1ps
interface bus_dma_master_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/bus_dma_master.sv
// Word-copy DMA initiator: copies len_words 32-bit words from src_addr to dst_addr
// as read/write pairs on the native valid/ready bus, one idle cycle after each transfer.
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        job start pulse (IDLE only), stop request at pair boundary
//   src_addr, dst_addr  byte addresses, bits[1:0] forced to zero
//   len_words           word count
//   busy, done          job active, 1-cycle completion pulse
//   aborted, bus_error  sticky status of the last job
//   words_done          completed write transfers of the current/last job
//   mem                 bus master modport
`timescale 1ns/1ps
module bus_dma_master #(
    parameter int unsigned LEN_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] len_words,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic                 bus_error,
    output logic [LEN_WIDTH-1:0] words_done,
    bus_dma_master_if.master     mem
);

    localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]   ALIGN  = 32'hFFFF_FFFC;
    localparam logic [31:0]   WORD   = 32'd4;

    typedef enum logic [2:0] {IDLE, RD, RGAP, WR, WGAP, FIN} state_t;

    state_t               state;
    logic [31:0]          src;
    logic [31:0]          dst;
    logic [31:0]          buffer;
    logic [LEN_WIDTH-1:0] remaining;
    logic [TW-1:0]        tcnt;
    logic                 abort_pend;

    // Single-process FSM; every output is a register so mem_valid drops with rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            src           <= '0;
            dst           <= '0;
            buffer        <= '0;
            remaining     <= '0;
            tcnt          <= '0;
            abort_pend    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            bus_error     <= 1'b0;
            words_done    <= '0;
            mem.mem_valid <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wstrb <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                abort_pend <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    // abort in this cycle is deliberately not latched: start wins
                    if (start) begin
                        src        <= src_addr & ALIGN;
                        dst        <= dst_addr & ALIGN;
                        remaining  <= len_words;
                        words_done <= '0;
                        aborted    <= 1'b0;
                        bus_error  <= 1'b0;
                        abort_pend <= 1'b0;
                        busy       <= 1'b1;
                        tcnt       <= '0;
                        if (len_words == '0) begin
                            state <= FIN;
                        end else begin
                            state         <= RD;
                            mem.mem_valid <= 1'b1;
                            mem.mem_addr  <= src_addr & ALIGN;
                            mem.mem_wstrb <= 4'h0;
                        end
                    end
                end

                RD: begin
                    if (mem.mem_ready) begin
                        buffer        <= mem.mem_rdata;
                        src           <= src + WORD;
                        mem.mem_valid <= 1'b0;
                        state         <= RGAP;
                    end else if (tcnt == T_LAST) begin
                        mem.mem_valid <= 1'b0;
                        bus_error     <= 1'b1;
                        state         <= FIN;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                RGAP: begin
                    state         <= WR;
                    tcnt          <= '0;
                    mem.mem_valid <= 1'b1;
                    mem.mem_addr  <= dst;
                    mem.mem_wdata <= buffer;
                    mem.mem_wstrb <= 4'hF;
                end

                WR: begin
                    if (mem.mem_ready) begin
                        dst           <= dst + WORD;
                        remaining     <= remaining - LEN_WIDTH'(1);
                        words_done    <= words_done + LEN_WIDTH'(1);
                        mem.mem_valid <= 1'b0;
                        state         <= WGAP;
                    end else if (tcnt == T_LAST) begin
                        mem.mem_valid <= 1'b0;
                        bus_error     <= 1'b1;
                        state         <= FIN;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                // Pair boundary: the only place a pending abort takes effect
                WGAP: begin
                    if (remaining == '0 || abort_pend || abort) begin
                        state <= FIN;
                    end else begin
                        state         <= RD;
                        tcnt          <= '0;
                        mem.mem_valid <= 1'b1;
                        mem.mem_addr  <= src;
                        mem.mem_wstrb <= 4'h0;
                    end
                end

                FIN: begin
                    // An abort that coincided with the last pair is a normal finish
                    aborted <= abort_pend & ~bus_error & (remaining != '0);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_dma_master.sv
// Self-checking bench for bus_dma_master: behavioural memory/slave with random stalls,
// a job-level reference model, and directed plus randomized copy jobs.
`timescale 1ns/1ps
module tb_bus_dma_master;

    localparam int unsigned LW = 16;
    localparam int unsigned TO = 256;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] data;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [31:0]   src_addr;
    logic [31:0]   dst_addr;
    logic [LW-1:0] len_words;
    logic          busy;
    logic          done;
    logic          aborted;
    logic          bus_error;
    logic [LW-1:0] words_done;

    bus_dma_master_if mem_bus ();

    bus_dma_master #(.LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len_words  (len_words),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .bus_error  (bus_error),
        .words_done (words_done),
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic [31:0] mem_model [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic bit unmapped(input logic [31:0] a);
        return a[31:28] == 4'h2;
    endfunction

    // ---------------- slave / bus monitor (acts mid-cycle) ----------------
    txn_t        log_q[$];
    int          stall_max   = 0;
    bit          noise       = 0;
    int          stall       = 0;
    bit          in_req      = 0;
    int          run         = 0;
    int          last_run    = 0;
    int          rd_req_seen = 0;
    int          wr_req_seen = 0;
    int          valid_cycles = 0;
    bit          prev_hs     = 0;
    bit          prev_rd     = 0;
    bit          gap_rd      = 0;
    bit          prev_vnh    = 0;
    bit          cur_hs;
    bit          cur_rd;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic [3:0]  p_wstrb;
    txn_t        t;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_req = 0; prev_hs = 0; prev_rd = 0; gap_rd = 0; prev_vnh = 0;
            mem_bus.mem_ready = 1'b0;
            mem_bus.mem_rdata = '0;
        end else begin
            cur_hs = 0;
            cur_rd = 0;
            mem_bus.mem_rdata = $urandom;
            if (prev_hs) chk("gap_after_transfer", 32'(mem_bus.mem_valid), 32'd0);
            if (gap_rd)  chk("write_after_read_gap", 32'(mem_bus.mem_valid), 32'd1);
            if (prev_vnh && mem_bus.mem_valid) begin
                chk("stable_addr",  mem_bus.mem_addr,  p_addr);
                chk("stable_wdata", mem_bus.mem_wdata, p_wdata);
                chk("stable_wstrb", 32'(mem_bus.mem_wstrb), 32'(p_wstrb));
            end
            if (mem_bus.mem_valid) begin
                valid_cycles++;
                if (!in_req) begin
                    in_req = 1;
                    run    = 0;
                    stall  = unmapped(mem_bus.mem_addr) ? -1 : $urandom_range(0, stall_max);
                    if (mem_bus.mem_wstrb == 4'h0) rd_req_seen++;
                    else wr_req_seen++;
                end
                run++;
                if (stall == 0) begin
                    mem_bus.mem_ready = 1'b1;
                    t.addr  = mem_bus.mem_addr;
                    t.wstrb = mem_bus.mem_wstrb;
                    if (mem_bus.mem_wstrb == 4'h0) begin
                        mem_bus.mem_rdata = mem_rd(mem_bus.mem_addr);
                        t.data = mem_bus.mem_rdata;
                        cur_rd = 1;
                    end else begin
                        mem_model[mem_bus.mem_addr] = mem_bus.mem_wdata;
                        t.data = mem_bus.mem_wdata;
                    end
                    log_q.push_back(t);
                    cur_hs   = 1;
                    in_req   = 0;
                    last_run = run;
                end else begin
                    mem_bus.mem_ready = 1'b0;
                    if (stall > 0) stall--;
                end
            end else begin
                if (in_req) begin
                    last_run = run;
                    in_req   = 0;
                end
                // ready outside a request must be ignored by the master
                mem_bus.mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            gap_rd   = prev_rd && !mem_bus.mem_valid;
            prev_hs  = cur_hs;
            prev_rd  = cur_rd;
            prev_vnh = mem_bus.mem_valid && !cur_hs;
            p_addr   = mem_bus.mem_addr;
            p_wdata  = mem_bus.mem_wdata;
            p_wstrb  = mem_bus.mem_wstrb;
        end
    end

    // ---------------- job runner with reference model ----------------
    task automatic run_job(input logic [31:0] s, input logic [31:0] d, input int n,
                           input int abort_k, input int smax, input bit spurious,
                           input bit check_time, input bit abort_with_start);
        txn_t        exp_q[$];
        txn_t        e;
        int          exp_wr = 0;
        bit          e_err  = 0;
        bit          e_ab   = 0;
        logic [31:0] sa;
        logic [31:0] da;
        int          cyc = 0;
        int          busy_cyc = 0;
        bit          got = 0;
        bit          sent = 0;

        // Expected job outcome from the copy semantics alone
        for (int i = 0; i < n; i++) begin
            sa = (s & 32'hFFFF_FFFC) + 32'(4 * i);
            da = (d & 32'hFFFF_FFFC) + 32'(4 * i);
            if (unmapped(sa)) begin e_err = 1; break; end
            e.addr = sa; e.wstrb = 4'h0; e.data = mem_rd(sa);
            exp_q.push_back(e);
            if (unmapped(da)) begin e_err = 1; break; end
            e.addr = da; e.wstrb = 4'hF; e.data = mem_rd(sa);
            exp_q.push_back(e);
            exp_wr++;
            if (abort_k > 0 && i + 1 >= abort_k && i + 1 < n) begin e_ab = 1; break; end
        end

        log_q.delete();
        rd_req_seen  = 0;
        wr_req_seen  = 0;
        valid_cycles = 0;
        stall_max    = smax;
        noise        = (smax > 0);

        @(posedge clk); #1;
        src_addr  = s;
        dst_addr  = d;
        len_words = LW'(n);
        start     = 1'b1;
        abort     = abort_with_start;
        while (!got && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            if (busy) busy_cyc++;
            if (done) begin
                got = 1;
            end else begin
                if (abort_k > 0 && !sent && rd_req_seen >= abort_k) begin
                    abort = 1'b1;
                    sent  = 1;
                end
                if (spurious && busy && $urandom_range(0, 3) == 0) begin
                    start     = 1'b1;
                    src_addr  = $urandom;
                    dst_addr  = $urandom;
                    len_words = LW'($urandom);
                end
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("busy_span", 32'(busy_cyc), 32'(cyc - 1));
        chk("words_done", 32'(words_done), 32'(exp_wr));
        chk("aborted", 32'(aborted), 32'(e_ab));
        chk("bus_error", 32'(bus_error), 32'(e_err));
        chk("txn_count", 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk("txn_addr", log_q[i].addr, exp_q[i].addr);
            chk("txn_wstrb", 32'(log_q[i].wstrb), 32'(exp_q[i].wstrb));
            if (exp_q[i].wstrb == 4'hF) chk("txn_wdata", log_q[i].data, exp_q[i].data);
        end
        if (n == 0) chk("no_traffic", 32'(valid_cycles), 32'd0);
        if (check_time) chk("done_latency", 32'(cyc), 32'(2 + 4 * exp_wr));
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int wait_cyc;
        logic [31:0] s;
        logic [31:0] d;
        int n;
        int ak;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len_words = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
        chk("rst_words_done", 32'(words_done), 32'd0);
        chk("rst_mem_valid", 32'(mem_bus.mem_valid), 32'd0);

        // Basic copy RAM -> accelerator, zero-wait
        mem_model[32'h0001_0000] = 32'h11;
        mem_model[32'h0001_0004] = 32'h22;
        mem_model[32'h0001_0008] = 32'h33;
        mem_model[32'h0001_000C] = 32'h44;
        run_job(32'h0001_0000, 32'h1000_0000, 4, 0, 0, 0, 1, 0);
        chk("accel_word0", mem_rd(32'h1000_0000), 32'h11);
        chk("accel_word3", mem_rd(32'h1000_000C), 32'h44);

        // Zero-length job
        run_job(32'h0001_0100, 32'h1000_0100, 0, 0, 0, 0, 1, 0);

        // Write to unmapped target times out
        run_job(32'h0001_0200, 32'h2000_0000, 4, 0, 0, 0, 0, 0);
        chk("timeout_valid_cycles", 32'(last_run), 32'(TO));

        // Read from unmapped source times out with no write
        run_job(32'h2000_0800, 32'h1000_0800, 2, 0, 0, 0, 0, 0);

        // Random stalls with start pulses while busy
        run_job(32'h0001_1000, 32'h1000_1000, 8, 0, 5, 1, 0, 0);

        // Abort during the 3rd read
        run_job(32'h0001_2000, 32'h1000_2000, 8, 3, 2, 0, 0, 0);

        // Abort during the last pair is a normal finish
        run_job(32'h0001_2100, 32'h1000_2100, 3, 3, 0, 0, 1, 0);

        // start and abort together in IDLE: abort ignored; unaligned inputs
        run_job(32'h0001_2203, 32'h1000_2302, 2, 0, 0, 0, 1, 1);

        // Reset asserted while a write is stalled
        stall_max = 0; noise = 0; wr_req_seen = 0;
        @(posedge clk); #1;
        src_addr = 32'h0001_3000; dst_addr = 32'h2000_3000; len_words = LW'(4); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_cyc = 0;
        while (wr_req_seen < 1 && wait_cyc < 100) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        chk("write_request_seen", 32'(wr_req_seen), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("stall_valid_before_rst", 32'(mem_bus.mem_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(mem_bus.mem_valid), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_job(32'h0001_3100, 32'h1000_3100, 3, 0, 0, 0, 1, 0);

        // Randomized jobs
        for (int j = 0; j < 6; j++) begin
            s  = 32'h0001_4000 + 32'(j * 64) + 32'($urandom_range(0, 3));
            d  = 32'h1000_0400 + 32'(j * 64) + 32'($urandom_range(0, 3));
            n  = $urandom_range(1, 6);
            ak = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n) : 0;
            run_job(s, d, n, ak, $urandom_range(0, 3), 1, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
